// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults and stream-sink FSM states
package vga_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  localparam int FIFO_DEPTH_D = 1024;
  typedef enum logic [1:0] {WAIT_SOF, ARMED, STREAM} state_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: show-ahead synchronous FIFO with flush and registered full/empty flags
module pixel_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nx;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign count_nx = flush ? '0 : count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + AW'(do_push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(do_pop);
      count <= count_nx;
      full <= count_nx == (AW+1)'(DEPTH);
      empty <= count_nx == '0;
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/vga_stream_sink.sv
// vga_stream_sink: AXI-Stream pixel sink driving registered VGA pins with frame alignment
module vga_stream_sink
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        locked,
  output logic [15:0] underflow_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  state_t state, state_nx;
  logic full, empty, push, pop, flush, active, origin, live, starve, misalign, h_last, v_last;
  logic [24:0] head;
  assign h_last = h == HW'(H_TOTAL - 1);
  assign v_last = v == VW'(V_TOTAL - 1);
  assign active = h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
  assign origin = h == '0 && v == '0;
  // ARMED already shows pixel (0,0) on the cycle it hands over to STREAM
  assign live = state == STREAM || (state == ARMED && origin);
  assign starve = live && active && empty;
  assign misalign = live && active && !empty && head[24] && !origin;
  assign pop = live && active && !empty && !misalign;
  assign flush = starve || misalign;
  assign s_axis_tready = aresetn && (state == WAIT_SOF || !full);
  assign push = s_axis_tvalid && s_axis_tready && (state != WAIT_SOF || s_axis_tuser);
  assign locked = state == STREAM;
  always_comb
    state_nx = flush ? WAIT_SOF : pop ? STREAM : (state == WAIT_SOF && push) ? ARMED : state;
  pixel_fifo #(.WIDTH(25), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(aclk),
    .rst_n(aresetn),
    .flush(flush),
    .push(push),
    .pop(pop),
    .wdata({s_axis_tuser, s_axis_tdata}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      h <= '0;
      v <= '0;
      state <= WAIT_SOF;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      {vga_r, vga_g, vga_b} <= '0;
      underflow_count <= '0;
    end else begin
      h <= h_last ? '0 : h + HW'(1);
      if (h_last) v <= v_last ? '0 : v + VW'(1);
      state <= state_nx;
      vga_hs <= !(h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC));
      vga_vs <= !(v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC));
      {vga_r, vga_g, vga_b} <= pop ? {head[23:20], head[15:12], head[7:4]} : 12'h0;
      if (starve && underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
    end
endmodule

// File: tb/tb_vga_stream_sink.sv
// tb_vga_stream_sink: randomized frame-stream bench with a queue-based reference model
module tb_vga_stream_sink;
  localparam int HA = 20, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 18, VFP = 1, VS = 2, VBP = 1;
  localparam int DEPTH = 16;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [23:0] s_axis_tdata = '0;
  logic s_axis_tuser = 1'b0, s_axis_tvalid = 1'b0, s_axis_tready;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, locked;
  logic [15:0] underflow_count;
  logic [30:0] pins, exp_pins;
  logic exp_rdy, rdy_seen;
  int n_vec = 0, n_err = 0;
  int mh, mv, mst, muf, ph, pv, sh, sv;
  bit inj;
  logic [24:0] q[$];

  vga_stream_sink #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs), .locked(locked), .underflow_count(underflow_count));

  assign pins = {vga_r, vga_g, vga_b, vga_hs, vga_vs, locked, underflow_count};
  initial forever #5 aclk = ~aclk;

  task automatic model_reset;
    mh = 0; mv = 0; mst = 0; muf = 0; sh = 0; sv = 0; inj = 0;
    q.delete();
  endtask

  // one pixel clock: random source beat, reference model step, DUT edge
  task automatic tick(input int pv8);
    logic acc, act, org, live, pop, flush, push;
    logic [11:0] rgb;
    int nst;
    @(negedge aclk);
    s_axis_tvalid = $urandom_range(7) < pv8;
    s_axis_tdata = {sh[7:0], sv[7:0], 8'hAA};
    s_axis_tuser = (sh == 0 && sv == 0) || (inj && sh == 5 && sv == 3);
    #1 rdy_seen = s_axis_tready;
    exp_rdy = mst == 0 || q.size() < DEPTH;
    acc = s_axis_tvalid && exp_rdy;
    act = mh < HA && mv < VA;
    org = mh == 0 && mv == 0;
    live = mst == 2 || (mst == 1 && org);
    pop = 0; flush = 0; rgb = '0; nst = mst;
    if (live && act) begin
      if (q.size() == 0) begin
        flush = 1; nst = 0;
        if (muf < 65535) muf++;
      end else if (q[0][24] && !org) begin
        flush = 1; nst = 0;
      end else begin
        pop = 1; nst = 2;
        rgb = {q[0][23:20], q[0][15:12], q[0][7:4]};
      end
    end
    push = acc && (mst != 0 || s_axis_tuser);
    if (mst == 0 && push) nst = 1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back({s_axis_tuser, s_axis_tdata});
    if (flush) q.delete();
    exp_pins = {rgb, !(mh >= HA + HFP && mh < HA + HFP + HS), !(mv >= VA + VFP && mv < VA + VFP + VS),
                nst == 2, muf[15:0]};
    ph = mh; pv = mv; mst = nst;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else mh++;
    if (acc) begin
      if (s_axis_tuser && !(sh == 0 && sv == 0)) inj = 0;
      sh++;
      if (sh == HA) begin
        sh = 0;
        sv = (sv == VA - 1) ? 0 : sv + 1;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    s_axis_tvalid = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    n_vec++;
    if (pins !== {12'h0, 1'b1, 1'b1, 1'b0, 16'h0} || s_axis_tready !== 1'b0) begin
      n_err++;
      $display("FAIL reset: pins %h rdy %b, want %h rdy 0", pins, s_axis_tready, {12'h0, 3'b110, 16'h0});
    end
    s_axis_tvalid = 1'b0;
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_idle;
    int hs_low = 0, vs_low = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(0);
      n_vec++;
      if (pins !== exp_pins || rdy_seen !== exp_rdy) begin
        n_err++;
        if (n_err <= 20) $display("FAIL idle (%0d,%0d): pins %h rdy %b, want %h rdy %b", ph, pv, pins, rdy_seen, exp_pins, exp_rdy);
      end
      if (i >= FRAME) begin
        hs_low += int'(!vga_hs);
        vs_low += int'(!vga_vs);
      end
    end
    n_vec++;
    if (hs_low != HS * VT || vs_low != VS * HT) begin
      n_err++;
      $display("FAIL idle_sync_widths: hs_low %0d vs_low %0d, want %0d %0d", hs_low, vs_low, HS * VT, VS * HT);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 5 * FRAME; i++) begin
      tick(7);
      n_vec++;
      if (pins !== exp_pins || rdy_seen !== exp_rdy) begin
        n_err++;
        if (n_err <= 20) $display("FAIL stream (%0d,%0d): pins %h rdy %b, want %h rdy %b", ph, pv, pins, rdy_seen, exp_pins, exp_rdy);
      end
      if (locked && ph < HA && pv < VA) begin
        n_vec++;
        if ({vga_r, vga_g, vga_b} !== {4'(ph >> 4), 4'(pv >> 4), 4'hA}) begin
          n_err++;
          if (n_err <= 20) $display("FAIL stream_pixel (%0d,%0d): rgb %h, want %h", ph, pv, {vga_r, vga_g, vga_b}, {4'(ph >> 4), 4'(pv >> 4), 4'hA});
        end
      end
    end
    n_vec++;
    if (locked !== 1'b1 || underflow_count !== 16'h0) begin
      n_err++;
      $display("FAIL stream_locked: locked %b uf %0d, want 1 0", locked, underflow_count);
    end
  endtask

  task automatic test_stall;
    int uf0;
    for (int i = 0; i < 2 * FRAME && !(ph == 0 && pv == 5); i++) tick(7);
    uf0 = muf;
    for (int i = 0; i < 300; i++) begin
      tick(0);
      n_vec++;
      if (pins !== exp_pins || rdy_seen !== exp_rdy) begin
        n_err++;
        if (n_err <= 20) $display("FAIL stall (%0d,%0d): pins %h rdy %b, want %h rdy %b", ph, pv, pins, rdy_seen, exp_pins, exp_rdy);
      end
    end
    n_vec++;
    if (locked !== 1'b0 || underflow_count !== 16'(uf0 + 1)) begin
      n_err++;
      $display("FAIL stall_underflow: locked %b uf %0d, want 0 %0d", locked, underflow_count, uf0 + 1);
    end
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick(7);
      n_vec++;
      if (pins !== exp_pins || rdy_seen !== exp_rdy) begin
        n_err++;
        if (n_err <= 20) $display("FAIL stall_resume (%0d,%0d): pins %h rdy %b, want %h rdy %b", ph, pv, pins, rdy_seen, exp_pins, exp_rdy);
      end
    end
    n_vec++;
    if (locked !== 1'b1 || underflow_count !== 16'(uf0 + 1)) begin
      n_err++;
      $display("FAIL stall_relock: locked %b uf %0d, want 1 %0d", locked, underflow_count, uf0 + 1);
    end
  endtask

  task automatic test_misalign;
    int uf0 = muf;
    bit black_seen = 0;
    for (int i = 0; i < 2 * FRAME && !(ph == 0 && pv == 10); i++) tick(7);
    inj = 1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick(7);
      n_vec++;
      if (pins !== exp_pins || rdy_seen !== exp_rdy) begin
        n_err++;
        if (n_err <= 20) $display("FAIL misalign (%0d,%0d): pins %h rdy %b, want %h rdy %b", ph, pv, pins, rdy_seen, exp_pins, exp_rdy);
      end
      if (ph == 5 && pv == 3 && !inj && !black_seen && i < 2 * FRAME)
        black_seen = {vga_r, vga_g, vga_b} === 12'h0 && locked === 1'b0;
    end
    n_vec++;
    if (!black_seen || locked !== 1'b1 || underflow_count !== 16'(uf0)) begin
      n_err++;
      $display("FAIL misalign_effect: black %b locked %b uf %0d, want 1 1 %0d", black_seen, locked, underflow_count, uf0);
    end
  endtask

  task automatic test_burst;
    int stalls = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(8);
      n_vec++;
      if (pins !== exp_pins || rdy_seen !== exp_rdy) begin
        n_err++;
        if (n_err <= 20) $display("FAIL burst (%0d,%0d): pins %h rdy %b, want %h rdy %b", ph, pv, pins, rdy_seen, exp_pins, exp_rdy);
      end
      stalls += int'(rdy_seen === 1'b0);
      if (locked && ph < HA && pv < VA) begin
        n_vec++;
        if ({vga_r, vga_g, vga_b} !== {4'(ph >> 4), 4'(pv >> 4), 4'hA}) begin
          n_err++;
          if (n_err <= 20) $display("FAIL burst_pixel (%0d,%0d): rgb %h, want %h", ph, pv, {vga_r, vga_g, vga_b}, {4'(ph >> 4), 4'(pv >> 4), 4'hA});
        end
      end
    end
    n_vec++;
    if (stalls == 0 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL burst_backpressure: stalls %0d locked %b, want >0 1", stalls, locked);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2 * FRAME && !(ph == 5 && pv == 3 && locked); i++) tick(7);
    n_vec++;
    if (!(ph == 5 && pv == 3 && locked === 1'b1)) begin
      n_err++;
      $display("FAIL reset_mid_reach: at (%0d,%0d) locked %b, want (5,3) 1", ph, pv, locked);
    end
    #2 aresetn = 1'b0;
    #1;
    n_vec++;
    if (pins !== {12'h0, 1'b1, 1'b1, 1'b0, 16'h0} || s_axis_tready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_abort: pins %h rdy %b, want %h rdy 0", pins, s_axis_tready, {12'h0, 3'b110, 16'h0});
    end
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    n_vec++;
    if (pins !== {12'h0, 1'b1, 1'b1, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_mid_hold: pins %h, want %h", pins, {12'h0, 3'b110, 16'h0});
    end
    aresetn = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(7);
      n_vec++;
      if (pins !== exp_pins || rdy_seen !== exp_rdy) begin
        n_err++;
        if (n_err <= 20) $display("FAIL reset_mid_restart (%0d,%0d): pins %h rdy %b, want %h rdy %b", ph, pv, pins, rdy_seen, exp_pins, exp_rdy);
      end
    end
    n_vec++;
    if (locked !== 1'b1 || underflow_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_relock: locked %b uf %0d, want 1 0", locked, underflow_count);
    end
  endtask

  initial begin
    model_reset();
    ph = 0; pv = 0;
    test_reset();
    test_idle();
    test_stream();
    test_stall();
    test_misalign();
    test_burst();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_stream_sink.md
VGA_STREAM_SINK -- requirements
Module: vga_stream_sink

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks (line total 800).
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines (frame total 525).
REQ-004 SHALL have parameter FIFO_DEPTH, default 1024, pixel buffer entries; power of two and at least 16.
REQ-005 SHALL have port aclk, input, 1, the only clock, which is also the pixel clock.
REQ-006 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port s_axis_tdata, input, 24, pixel {R[7:0],G[7:0],B[7:0]}.
REQ-008 SHALL have port s_axis_tuser, input, 1, start-of-frame marker, meaning pixel (0,0).
REQ-009 SHALL have ports s_axis_tvalid (input, 1) and s_axis_tready (output, 1), the AXI-Stream handshake.
REQ-010 SHALL have ports vga_r, vga_g, vga_b, output, 4 each, colour MSBs.
REQ-011 SHALL have ports vga_hs and vga_vs, output, 1 each, active-low syncs.
REQ-012 SHALL have port locked, output, 1, high while streaming an aligned frame.
REQ-013 SHALL have port underflow_count, output, 16, saturating count of starved active pixels.

Function
REQ-014 SHALL run free h/v counters; h wraps at line total-1 and increments v; v wraps at frame total-1 to 0.
REQ-015 SHALL accept a beat only when tvalid and tready are both high; tready = !fifo_full, except in WAIT_SOF where tready = 1.
REQ-016 SHALL implement a three-state FSM: WAIT_SOF, ARMED, STREAM.
REQ-017 In WAIT_SOF: SHALL drop beats with tuser=0; a beat with tuser=1 SHALL be written to the FIFO, and the FSM SHALL go to ARMED.
REQ-018 In ARMED: SHALL write beats to the FIFO and SHALL go to STREAM on the cycle where the counters equal h=0, v=0.
REQ-019 In STREAM: SHALL pop one FIFO entry on each active cycle (h<H_ACTIVE, v<V_ACTIVE) and no entry during blanking.
REQ-020 In STREAM: an empty FIFO on an active cycle SHALL output black, increment underflow_count (saturating at 0xFFFF), flush the FIFO, and go to WAIT_SOF.
REQ-021 In STREAM: a popped entry with tuser=1 at any position other than (0,0) SHALL be treated as misalignment: black output, FIFO flushed, go to WAIT_SOF; underflow_count SHALL NOT change.
REQ-022 A simultaneous push and pop SHALL both take effect; a push while full SHALL be impossible because tready=0.
REQ-023 SHALL drive locked = 1 exactly when the state is STREAM.
REQ-024 SHALL register all pins: the colour, HS and VS values for counter position (h,v) SHALL appear one cycle after the counters hold (h,v).
REQ-025 SHALL assert vga_hs low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vga_vs SHALL follow the same rule vertically.
REQ-026 SHALL output RGB = 0 during blanking and whenever the state is not STREAM; otherwise RGB = the upper nibbles of the popped tdata.

Reset
REQ-027 While aresetn=0: counters=0, state=WAIT_SOF, FIFO empty, tready=0, vga_hs=vga_vs=1, RGB=0, locked=0, underflow_count=0.
REQ-028 An assertion of aresetn mid-frame SHALL abort immediately, with no partial pixel output afterwards.
REQ-029 After deassertion, the first counter increment SHALL occur on the first aclk edge.

Structure
REQ-030 SHALL take the timing defaults and the FSM state enum from the shared package vga_pkg.
REQ-031 SHALL instantiate one sub-module, pixel_fifo: a synchronous FIFO, 25 bits wide (tdata+tuser), with a flush input and registered full/empty flags.

Verification
REQ-032 Reset, no input -> after 800*525 cycles: vga_hs low for 96 clocks per line, vga_vs low for 2 lines, RGB=0, locked=0.
REQ-033 Continuous frames starting with a tuser=1 beat, pixel value = {h[7:0], v[7:0], 8'hAA} -> from the second frame, pin RGB at (h,v) = that pixel's upper nibbles, locked=1, underflow_count=0.
REQ-034 Source stalls tvalid for 2000 cycles mid-frame -> black from the first starved active pixel, underflow_count=1, locked=0, relock at the next SOF+(0,0).
REQ-035 Inject tuser=1 at pixel 100 of line 5 -> output black, locked=0, underflow_count unchanged, realignment on the next frame.
REQ-036 Source always valid, bursting 1100 pixels early -> tready low when the FIFO holds 1024, no pixel lost or duplicated.
REQ-037 aresetn pulsed low at h=300,v=200 during STREAM -> all outputs at reset values within the same cycle, counters restart at 0.
